// File: rtl/rgen_pkg.sv
// Shared constants and types for the reel symbol generators.
// Parameter defaults live here so every reel generator agrees on them.
package rgen_pkg;

  localparam int              LFSR_W      = 16;
  localparam logic [15:0]     TAPS        = 16'hB400;
  localparam logic [15:0]     RESET_STATE = 16'hACE1;
  localparam int              NUM_SYMBOLS = 10;

  localparam int              SEED_W      = 6;
  localparam int              SYM_W       = 4;

  typedef logic [SYM_W-1:0] sym_t;

endpackage

// File: rtl/rgen_lfsr16.sv
// 16-bit Galois LFSR with a synchronous load port.
// Exposes the low byte of the next state so the owner can register a derived value in step.
module rgen_lfsr16 #(
  parameter int          LFSR_W      = rgen_pkg::LFSR_W,
  parameter logic [15:0] TAPS        = rgen_pkg::TAPS,
  parameter logic [15:0] RESET_STATE = rgen_pkg::RESET_STATE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  output logic [7:0]        low_byte
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] step_value;
  logic [LFSR_W-1:0] lfsr_next;

  always_comb begin
    step_value = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? TAPS : '0);
    lfsr_next  = load ? load_value : step_value;
    // A zero state would lock the register up; recover to the reset value.
    if (lfsr_next == '0) begin
      lfsr_next = RESET_STATE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= RESET_STATE;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign low_byte = lfsr_next[7:0];

endmodule

// File: rtl/rgen1.sv
// Reel 1 symbol generator: reloads the LFSR on a seed change and registers
// the low LFSR byte reduced modulo NUM_SYMBOLS.
module rgen1 #(
  parameter int          LFSR_W      = rgen_pkg::LFSR_W,
  parameter logic [15:0] TAPS        = rgen_pkg::TAPS,
  parameter logic [15:0] RESET_STATE = rgen_pkg::RESET_STATE,
  parameter int          NUM_SYMBOLS = rgen_pkg::NUM_SYMBOLS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [rgen_pkg::SEED_W-1:0] seed1,
  output logic [rgen_pkg::SYM_W-1:0]  rnum1
);

  import rgen_pkg::*;

  // Restoring long division by a constant; remainder stays below 2*NUM_SYMBOLS.
  function automatic sym_t mod_sym(input logic [7:0] value);
    logic [SYM_W:0] rem;
    rem = '0;
    for (int i = 7; i >= 0; i--) begin
      rem = {rem[SYM_W-1:0], value[i]};
      if (rem >= (SYM_W+1)'(NUM_SYMBOLS)) begin
        rem = rem - (SYM_W+1)'(NUM_SYMBOLS);
      end
    end
    return rem[SYM_W-1:0];
  endfunction

  logic [SEED_W-1:0] seed_reg;
  sym_t              rnum_reg;
  logic              seed_change;
  logic [LFSR_W-1:0] seed_pattern;
  logic [7:0]        low_byte;

  assign seed_change  = (seed1 != seed_reg);
  // The fixed middle nibble keeps the loaded pattern nonzero for any seed.
  assign seed_pattern = {seed1, 4'b1010, seed1};

  rgen_lfsr16 #(
    .LFSR_W      (LFSR_W),
    .TAPS        (TAPS),
    .RESET_STATE (RESET_STATE)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (seed_change),
    .load_value (seed_pattern),
    .low_byte   (low_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_reg <= '0;
      rnum_reg <= '0;
    end else begin
      seed_reg <= seed1;
      rnum_reg <= mod_sym(low_byte);
    end
  end

  assign rnum1 = rnum_reg;

endmodule

// File: tb/tb_rgen1.sv
// Directed self-checking bench for rgen1 with hand-computed LFSR and symbol values.
module tb_rgen1;

  logic       clk;
  logic       rst_n;
  logic [5:0] seed1;
  logic [3:0] rnum1;

  int tests;
  int fails;

  rgen1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seed1 (seed1),
    .rnum1 (rnum1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
    $display("[TB] %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] seen;
    int         bad_range;
    int         bad_zero;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    seed1 = 6'd0;

    // Reset state
    #12;
    check("reset_rnum", {12'd0, rnum1}, 16'd0);
    check("reset_lfsr", dut.u_lfsr.lfsr_reg, 16'hACE1);

    // Release with seed 0: free-run from reset value
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("run0_lfsr", dut.u_lfsr.lfsr_reg, 16'hE270);
    check("run0_rnum", {12'd0, rnum1}, 16'd2);

    // Seed load and hold
    @(negedge clk);
    seed1 = 6'd25;
    tick();
    check("load25_lfsr", dut.u_lfsr.lfsr_reg, 16'h6699);
    check("load25_rnum", {12'd0, rnum1}, 16'd3);
    tick();
    check("hold25_lfsr", dut.u_lfsr.lfsr_reg, 16'h874C);
    check("hold25_rnum", {12'd0, rnum1}, 16'd6);

    // Seed changing every cycle
    @(negedge clk);
    seed1 = 6'd13;
    tick();
    check("chg13_lfsr", dut.u_lfsr.lfsr_reg, 16'h368D);
    check("chg13_rnum", {12'd0, rnum1}, 16'd1);
    @(negedge clk);
    seed1 = 6'd25;
    tick();
    check("chg25_rnum", {12'd0, rnum1}, 16'd3);
    @(negedge clk);
    seed1 = 6'd13;
    tick();
    check("rechg13_lfsr", dut.u_lfsr.lfsr_reg, 16'h368D);
    check("rechg13_rnum", {12'd0, rnum1}, 16'd1);

    // Mid-operation asynchronous reset, with seed 25 still applied afterwards
    @(negedge clk);
    seed1 = 6'd25;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rnum", {12'd0, rnum1}, 16'd0);
    check("midrst_lfsr", dut.u_lfsr.lfsr_reg, 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postrst_lfsr", dut.u_lfsr.lfsr_reg, 16'h6699);
    check("postrst_rnum", {12'd0, rnum1}, 16'd3);

    // Seed change while in reset: no effect until release
    @(negedge clk);
    rst_n = 1'b0;
    seed1 = 6'd13;
    tick();
    tick();
    check("inrst_rnum", {12'd0, rnum1}, 16'd0);
    check("inrst_lfsr", dut.u_lfsr.lfsr_reg, 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("relrst_lfsr", dut.u_lfsr.lfsr_reg, 16'h368D);
    check("relrst_rnum", {12'd0, rnum1}, 16'd1);

    // Range sweep: every seed, 1000 free-running cycles each
    seen = '0;
    for (int s = 0; s < 64; s++) begin
      bad_range = 0;
      bad_zero  = 0;
      @(negedge clk);
      seed1 = 6'(s);
      for (int c = 0; c < 1000; c++) begin
        tick();
        if (rnum1 >= 4'd10) bad_range++;
        else seen[rnum1] = 1'b1;
        if (dut.u_lfsr.lfsr_reg == 16'd0) bad_zero++;
      end
      check($sformatf("range_seed%0d", s), 16'(bad_range), 16'd0);
      check($sformatf("nonzero_seed%0d", s), 16'(bad_zero), 16'd0);
    end
    check("all_symbols_seen", {6'd0, seen}, 16'h03FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
